hilo_unit: RTL and testbench

Multi-cycle multiply/divide engine that owns the architectural HI/LO register pair of the CPU32 core. It executes mult/multu/div/divu iteratively over 32 cycles and mthi/mtlo in one cycle. It drives `hilo_q` back to the ALU for mfhi/mflo. It also raises `busy` so the pipeline stalls any HI/LO consumer until the result is committed.

---
 rtl/hilo_unit_pkg.sv | 33 +++
 rtl/hilo_step.sv | 42 ++++
 rtl/hilo_unit.sv | 156 +++++++++++++++
 tb/tb_hilo_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: shared widths, HI/LO operation codes, FSM state and step-mode
// types, plus a small helper used when latching signed operands.
package hilo_unit_pkg;

    localparam int unsigned WORD      = 32;
    localparam int unsigned DWORD     = 64;
    localparam int unsigned B_HILO_OP = 3;

    localparam logic [B_HILO_OP-1:0] HILO_OP_MULT  = 3'd0;
    localparam logic [B_HILO_OP-1:0] HILO_OP_MULTU = 3'd1;
    localparam logic [B_HILO_OP-1:0] HILO_OP_DIV   = 3'd2;
    localparam logic [B_HILO_OP-1:0] HILO_OP_DIVU  = 3'd3;
    localparam logic [B_HILO_OP-1:0] HILO_OP_MTHI  = 3'd4;
    localparam logic [B_HILO_OP-1:0] HILO_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StFix  = 2'd3
    } hilo_state_e;

    typedef enum logic {
        StepMul = 1'b0,
        StepDiv = 1'b1
    } step_mode_e;

    // Magnitude of a word when treated as signed; passthrough otherwise.
    function automatic logic [WORD-1:0] abs_word(input logic [WORD-1:0] v, input logic is_signed);
        return (is_signed && v[WORD-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_step.sv
// hilo_step: one combinational iteration of the multiply/divide datapath.
//   mode     - StepMul: LSB-first shift-add; StepDiv: restoring divide step
//   acc      - mult: 64-bit product accumulator; div: partial remainder in [32:0]
//   operand  - multiplicand (mult) or divisor (div)
//   bit_in   - current multiplier bit (mult) or next dividend bit (div)
//   acc_next - updated accumulator / remainder
//   q_bit    - quotient bit produced by a divide step (0 in mult mode)
module hilo_step
    import hilo_unit_pkg::*;
(
    input  step_mode_e       mode,
    input  logic [DWORD-1:0] acc,
    input  logic [WORD-1:0]  operand,
    input  logic             bit_in,
    output logic [DWORD-1:0] acc_next,
    output logic             q_bit
);

    logic [WORD:0]   sum;
    logic [WORD:0]   shifted;
    logic [WORD+1:0] diff;

    always_comb begin
        // Mult: add into the top half, then shift the whole product right so
        // that after 32 steps bit i of the multiplier has weight 2^i.
        sum     = {1'b0, acc[DWORD-1:WORD]} + {1'b0, (bit_in ? operand : {WORD{1'b0}})};
        // Div: remainder is always below the divisor, so 32 bits plus the new
        // dividend bit fit in 33 bits; diff's MSB is the borrow.
        shifted = {acc[WORD-1:0], bit_in};
        diff    = {1'b0, shifted} - {2'b00, operand};

        acc_next = '0;
        q_bit    = 1'b0;
        if (mode == StepMul) begin
            acc_next = {sum, acc[WORD-1:1]};
        end else begin
            q_bit    = ~diff[WORD+1];
            acc_next = {{(WORD-1){1'b0}}, (q_bit ? diff[WORD:0] : shifted)};
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: iterative multiply/divide engine owning the HI/LO register pair.
//   clk_cpu   - core clock
//   reset     - synchronous active-high reset
//   req_valid - request present this cycle
//   req_op    - HILO_OP_* operation code
//   rs, rt    - operands (rs also the mthi/mtlo source)
//   req_ready - high when a request can be accepted (~busy)
//   busy      - multi-cycle operation in flight
//   hilo_q    - committed {HI, LO}
module hilo_unit
    import hilo_unit_pkg::*;
(
    input  logic                 clk_cpu,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [B_HILO_OP-1:0] req_op,
    input  logic [WORD-1:0]      rs,
    input  logic [WORD-1:0]      rt,
    output logic                 req_ready,
    output logic                 busy,
    output logic [DWORD-1:0]     hilo_q
);

    hilo_state_e      state_q, state_d;
    logic [4:0]       count_q, count_d;
    logic [DWORD-1:0] acc_q, acc_d;
    logic [WORD-1:0]  opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [WORD-1:0]  sh_q, sh_d;         // multiplier, or dividend -> quotient
    logic [WORD-1:0]  rs_orig_q, rs_orig_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             is_div_q, is_div_d;
    logic [DWORD-1:0] hilo_d;

    step_mode_e       step_mode;
    logic             step_bit;
    logic [DWORD-1:0] step_acc;
    logic             step_q_bit;

    logic             op_signed;
    logic [WORD-1:0]  quot, rem;

    assign busy      = (state_q != StIdle);
    assign req_ready = ~busy;

    assign step_mode = (state_q == StDiv) ? StepDiv : StepMul;
    // Multiplier is consumed LSB-first; dividend bits are consumed MSB-first.
    assign step_bit  = (state_q == StDiv) ? sh_q[WORD-1] : sh_q[0];

    hilo_step u_step (
        .mode     (step_mode),
        .acc      (acc_q),
        .operand  (opnd_q),
        .bit_in   (step_bit),
        .acc_next (step_acc),
        .q_bit    (step_q_bit)
    );

    assign op_signed = (req_op == HILO_OP_MULT) || (req_op == HILO_OP_DIV);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        sh_d      = sh_q;
        rs_orig_d = rs_orig_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        hilo_d    = hilo_q;
        quot      = neg_quo_q ? (~sh_q + 1'b1) : sh_q;
        rem       = neg_rem_q ? (~acc_q[WORD-1:0] + 1'b1) : acc_q[WORD-1:0];

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    case (req_op)
                        HILO_OP_MTHI: hilo_d[DWORD-1:WORD] = rs;
                        HILO_OP_MTLO: hilo_d[WORD-1:0]     = rs;
                        HILO_OP_MULT, HILO_OP_MULTU, HILO_OP_DIV, HILO_OP_DIVU: begin
                            is_div_d  = (req_op == HILO_OP_DIV) || (req_op == HILO_OP_DIVU);
                            neg_quo_d = op_signed & (rs[WORD-1] ^ rt[WORD-1]);
                            neg_rem_d = op_signed & rs[WORD-1];
                            rs_orig_d = rs;
                            acc_d     = '0;
                            count_d   = '0;
                            if (is_div_d) begin
                                opnd_d  = abs_word(rt, op_signed);
                                sh_d    = abs_word(rs, op_signed);
                                state_d = StDiv;
                            end else begin
                                opnd_d  = abs_word(rs, op_signed);
                                sh_d    = abs_word(rt, op_signed);
                                state_d = StMul;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d   = step_acc;
                sh_d    = sh_q >> 1;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = StFix;
            end
            StDiv: begin
                acc_d   = step_acc;
                sh_d    = {sh_q[WORD-2:0], step_q_bit};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = StFix;
            end
            StFix: begin
                if (!is_div_q) begin
                    hilo_d = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
                end else if (opnd_q == '0) begin
                    // Divide by zero: fixed result, no sign correction.
                    hilo_d = {rs_orig_q, {WORD{1'b1}}};
                end else begin
                    hilo_d = {rem, quot};
                end
                count_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            sh_q      <= '0;
            rs_orig_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            hilo_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            sh_q      <= sh_d;
            rs_orig_q <= rs_orig_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            hilo_q    <= hilo_d;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: randomized and directed bench for hilo_unit against an
// arithmetic reference model of HI/LO behaviour.
module tb_hilo_unit;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] rs, rt;
    logic        req_ready, busy;
    logic [63:0] hilo_q;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] model_hilo = 64'd0;

    hilo_unit dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .rs        (rs),
        .rt        (rt),
        .req_ready (req_ready),
        .busy      (busy),
        .hilo_q    (hilo_q)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic with the HI/LO conventions.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] old);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd4: return {a, old[31:0]};
            3'd5: return {old[63:32], a};
            default: return old;
        endcase
    endfunction

    // Issue one request and follow it until idle (bounded). Reports busy
    // length and whether hilo_q held its old value while busy.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles, output bit held);
        logic [63:0] old;
        old       = hilo_q;
        held      = 1'b1;
        req_valid = 1'b1;
        req_op    = op;
        rs        = a;
        rt        = b;
        tick();
        req_valid = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            if (hilo_q !== old) held = 1'b0;
            busy_cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        rs = '0;
        rt = '0;
        tick();
        tick();
        vectors++;
        if (hilo_q !== 64'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: hilo=%h busy=%b ready=%b, want 0/0/1", hilo_q, busy, req_ready);
        end
        reset = 1'b0;
        model_hilo = 64'd0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2};
        logic [31:0] as[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h1234_5678,
                                32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] bs[6]  = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [63:0] want[6] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h1234_5678_FFFF_FFFF,
                                 64'h0000_0000_8000_0000, 64'hFFFF_FFF9_FFFF_FFFF};
        int n;
        bit held;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], n, held);
            vectors++;
            if (n !== 33 || !held) begin
                miscompares++;
                $display("FAIL directed_busy[%0d]: busy=%0d held=%b, want 33/1", i, n, held);
            end
            vectors++;
            if (hilo_q !== want[i]) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, hilo_q, want[i]);
            end
            model_hilo = want[i];
        end
    endtask

    task automatic test_back_to_back_mt();
        bit rose = 1'b0;
        req_valid = 1'b1;
        req_op = 3'd4;
        rs = 32'hAAAA_0000;
        tick();
        if (busy) rose = 1'b1;
        req_op = 3'd5;
        rs = 32'h0000_5555;
        tick();
        if (busy) rose = 1'b1;
        req_valid = 1'b0;
        vectors++;
        if (hilo_q !== 64'hAAAA_0000_0000_5555 || rose) begin
            miscompares++;
            $display("FAIL mthi_mtlo: got %h busy_rose=%b want aaaa000000005555/0", hilo_q, rose);
        end
        model_hilo = 64'hAAAA_0000_0000_5555;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        int n, want_n;
        bit held;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            exp = ref_result(op, a, b, model_hilo);
            want_n = (op <= 3'd3) ? 33 : 0;
            issue(op, a, b, n, held);
            vectors++;
            if (hilo_q !== exp || n !== want_n || !held) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d rs=%h rt=%h: got %h busy=%0d held=%b want %h busy=%0d",
                         i, op, a, b, hilo_q, n, held, exp, want_n);
            end
            model_hilo = exp;
        end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] exp;
        int n = 0;
        exp = ref_result(3'd0, 32'h0001_2345, 32'hFFFF_0F0F, model_hilo);
        req_valid = 1'b1;
        req_op = 3'd0;
        rs = 32'h0001_2345;
        rt = 32'hFFFF_0F0F;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        req_valid = 1'b1;
        req_op = 3'd5;
        rs = 32'hDEAD_BEEF;
        tick();
        req_op = 3'd2;
        rs = 32'd100;
        rt = 32'd7;
        tick();
        req_valid = 1'b0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        vectors++;
        if (hilo_q !== exp || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore: got %h busy=%b want %h/0", hilo_q, busy, exp);
        end
        model_hilo = exp;
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1;
        req_op = 3'd3;
        rs = 32'h7777_7777;
        rt = 32'd3;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (hilo_q !== 64'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: got %h busy=%b want 0/0", hilo_q, busy);
        end
        // Stays aborted: no late commit.
        repeat (30) tick();
        vectors++;
        if (hilo_q !== 64'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_commit: got %h busy=%b want 0/0", hilo_q, busy);
        end
        // Reset wins over a simultaneous request.
        req_valid = 1'b1;
        req_op = 3'd4;
        rs = 32'hCAFE_F00D;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if (hilo_q !== 64'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: got %h busy=%b want 0/0", hilo_q, busy);
        end
        model_hilo = 64'd0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_mt();
        test_random();
        test_busy_ignore();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
